// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: opcode and FSM state encodings shared by the counter scheduler
package counter_sched_pkg;
  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_RUN, OP_STOP} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starting at ptr
module rr_arbiter #(
  parameter int N = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic            en,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    // walk offsets from farthest to nearest so the nearest requester wins
    for (int k = N - 1; k >= 0; k--) begin
      if (en && req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        gnt_id = ID_W'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/counter_sched.sv
// counter_sched: shares an up-counter among requesters issuing LOAD/RUN/STOP commands
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int N_REQ = 2,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [CNT_W*N_REQ-1:0] val,
  output logic [N_REQ-1:0]       gnt,
  output logic [CNT_W-1:0]       cnt,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id
);
  state_e           state;
  logic [CNT_W-1:0] target, acc_val, cnt_inc;
  logic [ID_W-1:0]  owner, rr_ptr, arb_id, acc_id;
  logic [N_REQ-1:0] arb_gnt;
  op_e              acc_op;
  logic             accept, stop_ok;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req    (req),
    .en     (state == ST_IDLE && !rst),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );
  always_comb begin
    acc_id  = state == ST_IDLE ? arb_id : owner;
    acc_op  = op_e'(op[2*acc_id +: 2]);
    acc_val = val[CNT_W*acc_id +: CNT_W];
    stop_ok = state == ST_RUN && !rst && req[owner] && op_e'(op[2*owner +: 2]) == OP_STOP;
    gnt     = state == ST_IDLE ? arb_gnt : (stop_ok ? N_REQ'(1) << owner : '0);
    accept  = |(req & gnt);
    cnt_inc = cnt + 1'b1;
  end
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      target  <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      done <= 1'b0;
      if (accept) rr_ptr <= acc_id == ID_W'(N_REQ - 1) ? '0 : acc_id + 1'b1;
      case (state)
        ST_IDLE: if (accept) begin
          if (acc_op == OP_LOAD) cnt <= acc_val;
          if (acc_op == OP_RUN) begin
            target  <= acc_val;
            owner   <= acc_id;
            state   <= cnt == acc_val ? ST_DONE : ST_RUN;
            done    <= cnt == acc_val;
            done_id <= acc_id;
          end
        end
        ST_RUN: if (accept) begin
          // a STOP landing on the final count still leaves cnt at target
          state <= ST_IDLE;
          if (cnt_inc == target) cnt <= cnt_inc;
        end else begin
          cnt <= cnt_inc;
          if (cnt_inc == target) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            done_id <= owner;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed checks of arbitration, counting, wrap, abort, reset and STOP collision
module tb_counter_sched;
  import counter_sched_pkg::*;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] op;
  logic [7:0] val;
  logic [1:0] gnt;
  logic [3:0] cnt;
  logic       busy, done;
  logic       done_id;
  int n_cmp = 0;
  int n_err = 0;
  counter_sched #(.CNT_W(4), .N_REQ(2)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .val(val),
    .gnt(gnt), .cnt(cnt), .busy(busy), .done(done), .done_id(done_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] r, input op_e o0, input logic [3:0] v0,
                       input op_e o1, input logic [3:0] v1);
    req = r;
    op  = {o1, o0};
    val = {v1, v0};
  endtask
  task automatic idle_in();
    drive(2'b00, OP_NOP, 4'd0, OP_NOP, 4'd0);
  endtask
  task automatic st(input string tag, input logic [3:0] c, input logic b, input logic d);
    chk({tag, "_cnt"}, 32'(cnt), 32'(c));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_done"}, 32'(done), 32'(d));
  endtask
  initial begin
    rst = 1'b1;
    idle_in();
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    st("rst", 4'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    // 1: LOAD 3 then RUN to 7
    drive(2'b01, OP_LOAD, 4'd3, OP_NOP, 4'd0);
    #1 chk("t1_load_gnt", 32'(gnt), 32'b01);
    tick(); idle_in();
    st("t1_loaded", 4'd3, 1'b0, 1'b0);
    drive(2'b10, OP_NOP, 4'd0, OP_RUN, 4'd7);
    #1 chk("t1_run_gnt", 32'(gnt), 32'b10);
    tick(); idle_in();
    st("t1_acc", 4'd3, 1'b1, 1'b0);
    tick(); st("t1_c4", 4'd4, 1'b1, 1'b0);
    tick(); st("t1_c5", 4'd5, 1'b1, 1'b0);
    tick(); st("t1_c6", 4'd6, 1'b1, 1'b0);
    tick(); st("t1_c7", 4'd7, 1'b1, 1'b1);
    chk("t1_done_id", 32'(done_id), 32'd1);
    tick(); st("t1_end", 4'd7, 1'b0, 1'b0);
    // 2: contention after reset
    rst = 1'b1; tick(); rst = 1'b0;
    drive(2'b11, OP_RUN, 4'd2, OP_RUN, 4'd3);
    #1 chk("t2_tie_gnt", 32'(gnt), 32'b01);
    tick();
    drive(2'b10, OP_RUN, 4'd2, OP_RUN, 4'd3);
    #1 chk("t2_hold0_gnt", 32'(gnt), 32'b00);
    st("t2_acc", 4'd0, 1'b1, 1'b0);
    tick(); chk("t2_hold1_gnt", 32'(gnt), 32'b00);
    st("t2_c1", 4'd1, 1'b1, 1'b0);
    tick(); chk("t2_hold2_gnt", 32'(gnt), 32'b00);
    st("t2_c2", 4'd2, 1'b1, 1'b1);
    chk("t2_done_id", 32'(done_id), 32'd0);
    tick(); chk("t2_pend_gnt", 32'(gnt), 32'b10);
    st("t2_idle", 4'd2, 1'b0, 1'b0);
    tick(); idle_in();
    tick(); st("t2_r1_c3", 4'd3, 1'b1, 1'b1);
    chk("t2_r1_done_id", 32'(done_id), 32'd1);
    tick(); st("t2_r1_end", 4'd3, 1'b0, 1'b0);
    // 3: wrap and zero-length runs
    drive(2'b01, OP_LOAD, 4'd14, OP_NOP, 4'd0);
    tick(); idle_in();
    chk("t3_load14", 32'(cnt), 32'd14);
    drive(2'b01, OP_RUN, 4'd1, OP_NOP, 4'd0);
    #1 chk("t3_run_gnt", 32'(gnt), 32'b01);
    tick(); idle_in();
    tick(); st("t3_c15", 4'd15, 1'b1, 1'b0);
    tick(); st("t3_c0", 4'd0, 1'b1, 1'b0);
    tick(); st("t3_c1", 4'd1, 1'b1, 1'b1);
    tick(); st("t3_end", 4'd1, 1'b0, 1'b0);
    drive(2'b10, OP_NOP, 4'd0, OP_LOAD, 4'd5);
    tick(); idle_in();
    drive(2'b01, OP_RUN, 4'd5, OP_NOP, 4'd0);
    tick(); idle_in();
    st("t3_zero", 4'd5, 1'b1, 1'b1);
    chk("t3_zero_id", 32'(done_id), 32'd0);
    tick(); st("t3_zero_end", 4'd5, 1'b0, 1'b0);
    // 4: abort by owner STOP
    drive(2'b01, OP_LOAD, 4'd0, OP_NOP, 4'd0);
    tick();
    drive(2'b01, OP_RUN, 4'd12, OP_NOP, 4'd0);
    tick(); idle_in();
    repeat (5) tick();
    st("t4_c5", 4'd5, 1'b1, 1'b0);
    drive(2'b10, OP_NOP, 4'd0, OP_STOP, 4'd0);
    #1 chk("t4_nonowner_gnt", 32'(gnt), 32'b00);
    drive(2'b11, OP_STOP, 4'd0, OP_STOP, 4'd0);
    #1 chk("t4_owner_gnt", 32'(gnt), 32'b01);
    tick(); idle_in();
    st("t4_stopped", 4'd5, 1'b0, 1'b0);
    tick(); st("t4_after", 4'd5, 1'b0, 1'b0);
    // 5: async reset mid-RUN, rr_ptr left at 1 beforehand
    drive(2'b01, OP_LOAD, 4'd0, OP_NOP, 4'd0);
    tick();
    drive(2'b01, OP_RUN, 4'd10, OP_NOP, 4'd0);
    tick(); idle_in();
    repeat (6) tick();
    st("t5_c6", 4'd6, 1'b1, 1'b0);
    #2 rst = 1'b1;
    drive(2'b01, OP_LOAD, 4'd9, OP_NOP, 4'd0);
    #1 chk("t5_rst_gnt", 32'(gnt), 32'b00);
    st("t5_rst", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(2'b10, OP_NOP, 4'd0, OP_LOAD, 4'd2);
    #1 chk("t5_alone_gnt", 32'(gnt), 32'b10);
    drive(2'b11, OP_LOAD, 4'd9, OP_LOAD, 4'd2);
    #1 chk("t5_tie_gnt", 32'(gnt), 32'b01);
    tick(); idle_in();
    st("t5_load9", 4'd9, 1'b0, 1'b0);
    // 6: STOP collides with reaching target
    drive(2'b01, OP_RUN, 4'd11, OP_NOP, 4'd0);
    tick(); idle_in();
    tick(); st("t6_c10", 4'd10, 1'b1, 1'b0);
    drive(2'b01, OP_STOP, 4'd0, OP_NOP, 4'd0);
    #1 chk("t6_stop_gnt", 32'(gnt), 32'b01);
    tick(); idle_in();
    st("t6_coll", 4'd11, 1'b0, 1'b0);
    tick(); st("t6_after", 4'd11, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
